// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types, widths and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
  localparam int WR_COUNT_W = 16;
  function automatic int onehot2idx(input logic [15:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 16; i++) idx = |(v & (16'd1 << i)) ? i : idx;
    return idx;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: one-hot pick of the first set req at or above ptr, wrapping to 0.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);
  logic [2*NUM_REQ-1:0] dbl, back;
  logic [NUM_REQ-1:0]   rot, low;
  // rotate so ptr sits at bit 0, isolate lowest set bit, rotate back
  always_comb begin
    dbl  = {req, req} >> ptr;
    rot  = dbl[NUM_REQ-1:0];
    low  = rot & (~rot + NUM_REQ'(1));
    back = {low, low} << ptr;
    pick = back[2*NUM_REQ-1:NUM_REQ];
  end
  assign valid = |req;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one FIFO write port, with saturating write count.
// Define FIFO_ARB_LOCK_EN to let an owner hold the port for bursts of up to MAX_BURST beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [PW-1:0]                 gnt_id,
  output logic [WR_COUNT_W-1:0]         wr_count
);
`ifdef FIFO_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  arb_state_t state, state_n;
  logic [PW-1:0] rr_ptr, ptr_n, owner, owner_n;
  logic [7:0] beat_cnt, beat_n;
  logic [NUM_REQ-1:0] eff_req, pick;
  logic pick_valid;
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
    return (i == PW'(NUM_REQ - 1)) ? '0 : i + PW'(1);
  endfunction
  // a locked owner masks every other requester out of the search
  assign eff_req = (state == ARB_LOCKED) ? (req & (NUM_REQ'(1) << owner)) : req;
  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(eff_req),
    .ptr(rr_ptr),
    .pick(pick),
    .valid(pick_valid)
  );
  assign gnt        = (reset_n && !fifo_full && pick_valid) ? pick : '0;
  assign fifo_wr_en = |gnt;
  assign gnt_id     = PW'(onehot2idx(16'(gnt)));
  assign fifo_data  = fifo_wr_en ? DATA_WIDTH'(req_data >> (gnt_id * DATA_WIDTH)) : '0;
  always_comb begin
    state_n = state;
    owner_n = owner;
    beat_n  = beat_cnt;
    ptr_n   = rr_ptr;
    if (fifo_wr_en) begin
      if (state == ARB_IDLE) begin
        if (LOCK_EN && !req_last[gnt_id] && MAX_BURST > 1) begin
          state_n = ARB_LOCKED;
          owner_n = gnt_id;
          beat_n  = 8'd1;
        end else ptr_n = wrap_inc(gnt_id);
      end else if (req_last[owner] || ({1'b0, beat_cnt} + 9'd1 >= 9'(MAX_BURST))) begin
        state_n = ARB_IDLE;
        beat_n  = '0;
        ptr_n   = wrap_inc(owner);
      end else beat_n = beat_cnt + 8'd1;
    end else if (state == ARB_LOCKED && !fifo_full && !req[owner]) begin
      state_n = ARB_IDLE;
      beat_n  = '0;
      ptr_n   = wrap_inc(owner);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ARB_IDLE;
      owner    <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
      wr_count <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      beat_cnt <= beat_n;
      rr_ptr   <= ptr_n;
      if (fifo_wr_en && wr_count != '1) wr_count <= wr_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random stimulus against an in-bench arbitration model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
`ifdef FIFO_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, fifo_full = 1'b0;
  logic [N-1:0] req = '0, req_last = '0, gnt;
  logic [N*W-1:0] req_data = '0;
  logic fifo_wr_en;
  logic [W-1:0] fifo_data;
  logic [1:0] gnt_id;
  logic [15:0] wr_count;
  int checks = 0, errors = 0;
  int m_ptr = 0, m_owner = 0, m_beats = 0, m_count = 0;
  bit m_locked = 1'b0, armed = 1'b0;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .req_last(req_last),
    .fifo_full(fifo_full), .gnt(gnt), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
    .gnt_id(gnt_id), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // requester that must own the port this cycle, or -1
  function automatic int exp_gid();
    if (!reset_n || fifo_full) return -1;
    if (m_locked) return bit_of(req, m_owner) ? m_owner : -1;
    for (int k = 0; k < N; k++) if (bit_of(req, (m_ptr + k) % N)) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = exp_gid();
    if (!reset_n) begin
      armed <= 1'b1; m_ptr <= 0; m_locked <= 1'b0; m_beats <= 0; m_count <= 0;
    end else if (g >= 0) begin
      m_count <= (m_count >= 65535) ? 65535 : m_count + 1;
      if (m_locked) begin
        if (bit_of(req_last, g) || m_beats + 1 >= MB) begin
          m_locked <= 1'b0; m_beats <= 0; m_ptr <= (g + 1) % N;
        end else m_beats <= m_beats + 1;
      end else if (LOCK && !bit_of(req_last, g) && MB > 1) begin
        m_locked <= 1'b1; m_owner <= g; m_beats <= 1;
      end else m_ptr <= (g + 1) % N;
    end else if (m_locked && !fifo_full && !bit_of(req, m_owner)) begin
      m_locked <= 1'b0; m_beats <= 0; m_ptr <= (m_owner + 1) % N;
    end
  end

  always @(negedge clk) begin
    int g;
    if (armed) begin
      g = exp_gid();
      chk("gnt", int'(gnt), g < 0 ? 0 : (1 << g));
      chk("wr_en", int'(fifo_wr_en), g < 0 ? 0 : 1);
      chk("gnt_id", int'(gnt_id), g < 0 ? 0 : g);
      chk("data", int'(fifo_data), g < 0 ? 0 : int'(W'(req_data >> (g * W))));
      chk("wr_count", int'(wr_count), m_count);
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) adv();
    reset_n = 1'b1;
  endtask

  initial begin
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_wr_en", int'(fifo_wr_en), 0);
      adv();
    end
    reset_n = 1'b1;
    #2;
    chk("rst_count", int'(wr_count), 0);
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("fair_gid", int'(gnt_id), i % 4);
      chk("fair_wr_en", int'(fifo_wr_en), 1);
      adv();
    end
    req = '0;
    #2;
    chk("fair_count", int'(wr_count), 8);
    req = 4'b0100;
    #2; chk("wrap_gid2", int'(gnt_id), 2); adv();
    req = 4'b0101;
    #2; chk("wrap_gid0", int'(gnt_id), 0); adv();
    #2; chk("wrap_gid2b", int'(gnt_id), 2); adv();
    req = 4'b0010;
    req_data = 32'h0000_A500;
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("full_gnt", int'(gnt), 0);
      chk("full_count", int'(wr_count), 11);
      adv();
    end
    fifo_full = 1'b0;
    #2;
    chk("unfull_gnt", int'(gnt), 2);
    chk("unfull_data", int'(fifo_data), 8'hA5);
    adv();
    req = '0;
    #2;
    chk("unfull_count", int'(wr_count), 12);
`ifdef FIFO_ARB_LOCK_EN
    do_reset(2);
    req = 4'b0011;
    req_last = '0;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("lock_gid", int'(gnt_id), i < 4 ? 0 : 1);
      adv();
    end
    req = '0;
    adv();
    do_reset(2);
    req = 4'b0011;
    #2; chk("last_gid_a", int'(gnt_id), 0); adv();
    req_last = 4'b0001;
    #2; chk("last_gid_b", int'(gnt_id), 0); adv();
    req_last = '0;
    #2; chk("last_gid_c", int'(gnt_id), 1); adv();
    req = '0;
    adv();
`endif
    for (int i = 0; i < 400; i++) begin
      req       = N'($urandom);
      req_data  = $urandom;
      req_last  = ($urandom % 3 == 0) ? N'($urandom) : '0;
      fifo_full = ($urandom % 4 == 0);
      reset_n   = ($urandom % 40 != 0);
      adv();
    end
    fifo_full = 1'b0;
    req_last = '0;
    do_reset(2);
    req = 4'b1111;
    for (int i = 0; i < 65534; i++) adv();
    req = '0;
    #2;
    chk("sat_pre", int'(wr_count), 65534);
    req = 4'b1111;
    repeat (3) adv();
    req = '0;
    #2;
    chk("sat_max", int'(wr_count), 65535);
    adv();
    #2;
    chk("sat_hold", int'(wr_count), 65535);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
